// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with write-through bypass,
// hardwired-zero register 0 and a per-register busy-bit scoreboard used
// by decode to detect RAW hazards against in-flight producers.
module regfile_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              iss_stall,
  input  logic              flush,
  output logic              sb_err
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0]   regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            sb_err_q, sb_err_d;

  logic            wr_is_zero;
  logic            iss_is_zero;
  logic            wr_commit;
  logic            iss_apply;
  logic            iss_hit_wr;

  assign wr_is_zero  = (ZERO_REG != 0) && (wr_addr == '0);
  assign iss_is_zero = (ZERO_REG != 0) && (iss_addr == '0);
  assign wr_commit   = wr_en && !wr_is_zero;
  // A flush discards the issue of the same cycle; reg 0 is never tracked.
  assign iss_apply   = iss_en && !flush && !iss_is_zero;
  assign iss_hit_wr  = wr_en && (wr_addr == iss_addr);

  // Stall when the destination still has an outstanding producer that is
  // not retiring in this very cycle.
  assign iss_stall = iss_en && !iss_is_zero && busy_q[iss_addr] && !iss_hit_wr;
  assign sb_err    = sb_err_q;

  // Combinational read ports: zero register, then bypass, then storage.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      if ((ZERO_REG != 0) && (rd_addr[k*AW +: AW] == '0)) begin
        rd_data[k*DW +: DW] = '0;
        rd_busy[k]          = 1'b0;
      end else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr[k*AW +: AW])) begin
        rd_data[k*DW +: DW] = wr_data;
        rd_busy[k]          = 1'b0;
      end else begin
        rd_data[k*DW +: DW] = regs_q[rd_addr[k*AW +: AW]];
        rd_busy[k]          = busy_q[rd_addr[k*AW +: AW]];
      end
    end
  end

  // Scoreboard next state: flush wins, otherwise retire then issue so a
  // same-address retire+issue leaves the bit set for the new producer.
  always_comb begin
    busy_d   = busy_q;
    sb_err_d = sb_err_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_en) busy_d[wr_addr] = 1'b0;
      if (iss_apply) busy_d[iss_addr] = 1'b1;
      if (iss_stall) sb_err_d = 1'b1;
    end
  end

  // Register storage: cleared on reset, written from write-back otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_commit) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Scoreboard and sticky error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus randomized traffic checked
// against an array-based reference model of the register file.
module tb_regfile_sb;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;

  logic              clk;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              iss_stall;
  logic              flush;
  logic              sb_err;

  int vectors;
  int miscompares;

  // Reference model state
  logic [DW-1:0] m_reg  [32];
  logic          m_busy [32];
  logic          m_err;

  regfile_sb #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .iss_stall(iss_stall),
    .flush    (flush),
    .sb_err   (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !(wr_en && wr_addr == a);
  endfunction

  function automatic logic exp_stall();
    return iss_en && (iss_addr != 0) && m_busy[iss_addr] && !(wr_en && wr_addr == iss_addr);
  endfunction

  task automatic idle();
    rst = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    iss_en = 0; iss_addr = 0; flush = 0; rd_addr = 0;
  endtask

  // Advance one clock and bring the model to the post-edge state.
  task automatic tick();
    logic st;
    st = exp_stall();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
      m_err = 1'b0;
    end else begin
      if (wr_en && wr_addr != 0) m_reg[wr_addr] = wr_data;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
        if (wr_en) m_busy[wr_addr] = 1'b0;
        if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        if (st) m_err = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1; tick(); rst = 0;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {a[AW-1:0], a[AW-1:0]};
      #1;
      vectors++;
      if (rd_data !== '0 || rd_busy !== '0 || sb_err !== 1'b0) begin
        miscompares++;
        $display("FAIL reset addr=%0d data=%h busy=%b err=%b, want 0/00/0", a, rd_data, rd_busy, sb_err);
      end
    end
  endtask

  task automatic test_bypass();
    idle(); wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd5};
    #1; vectors++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL bypass got %h want deadbeef", rd_data[31:0]);
    end
    tick(); wr_en = 0; #1; vectors++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL stored_r5 got %h want deadbeef", rd_data[31:0]);
    end
  endtask

  task automatic test_zero_reg();
    idle(); wr_en = 1; wr_addr = 0; wr_data = 32'h1234; iss_en = 1; iss_addr = 0; rd_addr = '0;
    #1; vectors++;
    if (rd_data !== '0 || rd_busy !== '0 || iss_stall !== 1'b0) begin
      miscompares++; $display("FAIL zero_same data=%h busy=%b stall=%b want 0", rd_data, rd_busy, iss_stall);
    end
    tick(); idle(); iss_en = 1; iss_addr = 0; #1; vectors++;
    if (rd_data !== '0 || rd_busy !== '0 || iss_stall !== 1'b0) begin
      miscompares++; $display("FAIL zero_after data=%h busy=%b stall=%b want 0", rd_data, rd_busy, iss_stall);
    end
    tick(); idle();
  endtask

  task automatic test_busy_window();
    idle(); iss_en = 1; iss_addr = 7; tick();
    idle(); rd_addr = {5'd7, 5'd7};
    for (int c = 1; c <= 2; c++) begin
      #1; vectors++;
      if (rd_busy !== 2'b11) begin
        miscompares++; $display("FAIL busy_r7_c%0d got %b want 11", c, rd_busy);
      end
      tick();
    end
    vectors++;
    if (rd_busy !== 2'b11) begin
      miscompares++; $display("FAIL busy_r7_c3pre got %b want 11", rd_busy);
    end
    wr_en = 1; wr_addr = 7; wr_data = 32'h55; #1; vectors++;
    if (rd_busy !== 2'b00 || rd_data !== {32'h55, 32'h55}) begin
      miscompares++; $display("FAIL retire_r7 busy=%b data=%h want 00/55", rd_busy, rd_data);
    end
    tick(); wr_en = 0; #1; vectors++;
    if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'h55) begin
      miscompares++; $display("FAIL after_r7 busy=%b data=%h want 00/55", rd_busy, rd_data[31:0]);
    end
  endtask

  task automatic test_double_issue();
    idle(); iss_en = 1; iss_addr = 9; #1; vectors++;
    if (iss_stall !== 1'b0) begin
      miscompares++; $display("FAIL first_iss stall=%b want 0", iss_stall);
    end
    tick(); #1; vectors++;
    if (iss_stall !== 1'b1) begin
      miscompares++; $display("FAIL second_iss stall=%b want 1", iss_stall);
    end
    tick(); idle(); rd_addr = {5'd0, 5'd9}; #1; vectors++;
    if (sb_err !== 1'b1 || rd_busy[0] !== 1'b1) begin
      miscompares++; $display("FAIL sb_err_set err=%b busy=%b want 1/1", sb_err, rd_busy[0]);
    end
    flush = 1; tick(); flush = 0; #1; vectors++;
    if (rd_busy[0] !== 1'b0 || sb_err !== 1'b1) begin
      miscompares++; $display("FAIL flush busy=%b err=%b want 0/1", rd_busy[0], sb_err);
    end
    rst = 1; tick(); rst = 0; #1; vectors++;
    if (sb_err !== 1'b0) begin
      miscompares++; $display("FAIL err_rst got %b want 0", sb_err);
    end
  endtask

  task automatic test_reset_midflight();
    idle(); wr_en = 1; wr_addr = 3; wr_data = 32'hA5A5_0003; tick();
    idle(); iss_en = 1; iss_addr = 3; tick();
    idle(); rd_addr = {5'd3, 5'd3}; #1; vectors++;
    if (rd_busy !== 2'b11 || rd_data[31:0] !== 32'hA5A5_0003) begin
      miscompares++; $display("FAIL r3_inflight busy=%b data=%h want 11/a5a50003", rd_busy, rd_data[31:0]);
    end
    rst = 1; tick(); rst = 0; #1; vectors++;
    if (rd_busy !== 2'b00 || rd_data !== '0) begin
      miscompares++; $display("FAIL r3_rst busy=%b data=%h want 00/0", rd_busy, rd_data);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a0, a1;
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 99) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      wr_en    = $urandom_range(0, 1) != 0;
      wr_addr  = AW'($urandom_range(0, 7));
      wr_data  = $urandom;
      iss_en   = $urandom_range(0, 1) != 0;
      iss_addr = AW'($urandom_range(0, 7));
      a0       = AW'($urandom_range(0, 7));
      a1       = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, 31));
      rd_addr  = {a1, a0};
      #1; vectors++;
      if (rd_data[31:0] !== exp_rd(a0) || rd_data[63:32] !== exp_rd(a1) ||
          rd_busy !== {exp_busy(a1), exp_busy(a0)} ||
          iss_stall !== exp_stall() || sb_err !== m_err) begin
        miscompares++;
        $display("FAIL rand%0d data=%h busy=%b stall=%b err=%b want %h%h/%b%b/%b/%b", n,
                 rd_data, rd_busy, iss_stall, sb_err, exp_rd(a1), exp_rd(a0),
                 exp_busy(a1), exp_busy(a0), exp_stall(), m_err);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
    m_err = 1'b0;
    idle();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_busy_window();
    test_double_issue();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
